// File: rtl/bus_arbiter4_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter
// that owns the shared 4:1 source-mux select.
interface bus_arbiter4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       active;
  logic       expired;

  modport slave  (input req, output gnt, sel, active, expired);
  modport master (output req, input gnt, sel, active, expired);
endinterface

// File: rtl/bus_arbiter4.sv
// Four-requester round-robin arbiter with a one-cycle turnaround between owners.
// Optional burst limit enabled by defining ARB_BURST_LIMIT_EN (uses MAX_BURST).
//
// state | meaning
// IDLE  | no owner, arbitrate every cycle
// BUSY  | sel_q owns the mux, gnt held
// TURN  | one dead cycle after release, then arbitrate
module bus_arbiter4 #(
  parameter int MAX_BURST = 8
) (
  input  logic           clk,
  input  logic           rst,
  bus_arbiter4_if.slave  bus
);

  if (MAX_BURST < 2 || MAX_BURST > 255) begin : g_bad_max_burst
    $error("bus_arbiter4: MAX_BURST out of range 2..255");
  end

  typedef enum logic [1:0] {IDLE, BUSY, TURN} state_t;

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic       active_q, active_d;
  logic [1:0] last_q, last_d;

  logic       win_vld;
  logic [1:0] win_idx;

`ifdef ARB_BURST_LIMIT_EN
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       expired_q, expired_d;
  logic       others_req;

  assign others_req = |(bus.req & ~gnt_q);
`endif

  // Search upward from the slot after the last owner, so the previous owner ends up last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = last_q;
    for (int k = 1; k <= 4; k++) begin
      if (!win_vld && bus.req[last_q + 2'(k)]) begin
        win_vld = 1'b1;
        win_idx = last_q + 2'(k);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    active_d = active_q;
    last_d   = last_q;
`ifdef ARB_BURST_LIMIT_EN
    cnt_d     = cnt_q;
    expired_d = 1'b0;
`endif
    case (state_q)
      IDLE, TURN: begin
        if (win_vld) begin
          state_d  = BUSY;
          gnt_d    = 4'b0001 << win_idx;
          sel_d    = win_idx;
          active_d = 1'b1;
          last_d   = win_idx;
`ifdef ARB_BURST_LIMIT_EN
          cnt_d    = '0;
`endif
        end else begin
          state_d  = IDLE;
          gnt_d    = '0;
          active_d = 1'b0;
        end
      end
      BUSY: begin
        if (!bus.req[sel_q]) begin
          state_d  = TURN;
          gnt_d    = '0;
          active_d = 1'b0;
        end
`ifdef ARB_BURST_LIMIT_EN
        else if (cnt_q == BURST_LAST && others_req) begin
          state_d   = TURN;
          gnt_d     = '0;
          active_d  = 1'b0;
          expired_d = 1'b1;
        end else if (cnt_q != BURST_LAST) begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: begin
        state_d  = IDLE;
        gnt_d    = '0;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      sel_q     <= '0;
      active_q  <= 1'b0;
      last_q    <= 2'd3;
`ifdef ARB_BURST_LIMIT_EN
      cnt_q     <= '0;
      expired_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      active_q  <= active_d;
      last_q    <= last_d;
`ifdef ARB_BURST_LIMIT_EN
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
`endif
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.sel    = sel_q;
  assign bus.active = active_q;
`ifdef ARB_BURST_LIMIT_EN
  assign bus.expired = expired_q;
`else
  assign bus.expired = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter4.sv
// Bench for bus_arbiter4: directed scenarios plus random requests, all checked
// every cycle against an owner/pointer model of the arbitration rules.
module tb_bus_arbiter4;

  localparam int MAXB = 4;
`ifdef ARB_BURST_LIMIT_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  bus_arbiter4_if bus_if ();

  bus_arbiter4 #(.MAX_BURST(MAXB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: who owns the bus, how long it has held it, who owned it last.
  int         m_owner = -1;
  int         m_held  = 0;
  int         m_last  = 3;
  logic [1:0] m_sel   = 2'd0;
  bit         m_exp   = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1;
      m_held  = 0;
      m_last  = 3;
      m_sel   = 2'd0;
      m_exp   = 1'b0;
    end else begin
      m_exp = 1'b0;
      if (m_owner >= 0) begin
        if (!bus_if.req[m_owner]) begin
          m_owner = -1;
        end else if (BURST_EN && m_held >= MAXB &&
                     (bus_if.req & ~(4'b0001 << m_owner)) != 4'b0000) begin
          m_owner = -1;
          m_exp   = 1'b1;
        end else begin
          m_held++;
        end
      end else begin
        bit found;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          int i;
          i = (m_last + k) % 4;
          if (!found && bus_if.req[i]) begin
            found   = 1'b1;
            m_owner = i;
            m_last  = i;
            m_held  = 1;
            m_sel   = 2'(i);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] exp_gnt;
    exp_gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    check("gnt", 32'(bus_if.gnt), 32'(exp_gnt));
    check("sel", 32'(bus_if.sel), 32'(m_sel));
    check("active", 32'(bus_if.active), 32'(m_owner >= 0));
    check("expired", 32'(bus_if.expired), 32'(m_exp));
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.req = 4'b0000;
    cyc(2);
    rst = 1'b0;
  endtask

  logic [3:0] seq [5];
  logic [1:0] sseq[5];
  int         gaps[5];

  initial begin
    int n, run, gap, c1, nexp;
    logic [3:0] prev, r;
    bus_if.req = 4'b0000;
    #1 rst = 1'b1;
    #1;
    check("rst_gnt", 32'(bus_if.gnt), 32'h0);
    check("rst_sel", 32'(bus_if.sel), 32'h0);
    check("rst_active", 32'(bus_if.active), 32'h0);
    check("rst_expired", 32'(bus_if.expired), 32'h0);
    cyc(2);
    rst = 1'b0;

    // single requester grant and release
    bus_if.req = 4'b0001;
    cyc(1);
    check("t1_gnt", 32'(bus_if.gnt), 32'h1);
    check("t1_sel", 32'(bus_if.sel), 32'h0);
    check("t1_active", 32'(bus_if.active), 32'h1);
    bus_if.req = 4'b0000;
    cyc(1);
    check("t1_rel_gnt", 32'(bus_if.gnt), 32'h0);
    check("t1_rel_sel", 32'(bus_if.sel), 32'h0);
    cyc(2);

    // rotation with everyone requesting, each owner releases after 3 cycles
    do_reset();
    bus_if.req = 4'hF;
    n = 0; run = 0; gap = 0; prev = 4'b0000;
    for (int c = 0; c < 80 && n < 5; c++) begin
      cyc(1);
      if (bus_if.gnt != 4'b0000) begin
        if (prev == 4'b0000) begin
          seq[n] = bus_if.gnt; sseq[n] = bus_if.sel; gaps[n] = gap;
          n++; run = 0;
        end
        run++;
        if (run == 3) bus_if.req = 4'hF & ~bus_if.gnt;
        gap = 0;
      end else begin
        gap++;
        bus_if.req = 4'hF;
      end
      prev = bus_if.gnt;
    end
    check("rot_count", 32'(n), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check("rot_gnt", 32'(seq[i]), 32'(4'b0001 << (i % 4)));
      check("rot_sel", 32'(sseq[i]), 32'(i % 4));
      if (i > 0) check("rot_gap", 32'(gaps[i]), 32'd1);
    end
    bus_if.req = 4'b0000;
    cyc(3);

    // owner 2 ignores other requests until it releases; next is 3
    bus_if.req = 4'b0100;
    cyc(1);
    check("o2_gnt", 32'(bus_if.gnt), 32'h4);
    bus_if.req = 4'b1101;
    cyc(1);
    check("o2_hold1", 32'(bus_if.gnt), 32'h4);
    cyc(1);
    check("o2_hold2", 32'(bus_if.gnt), 32'h4);
    bus_if.req = 4'b1001;
    cyc(1);
    check("o2_turn", 32'(bus_if.gnt), 32'h0);
    cyc(1);
    check("o2_next", 32'(bus_if.gnt), 32'h8);
    check("o2_next_sel", 32'(bus_if.sel), 32'h3);
    bus_if.req = 4'b0000;
    cyc(3);

    // two requesters held continuously
    bus_if.req = 4'b0011;
    c1 = 0; nexp = 0;
    for (int c = 0; c < 20; c++) begin
      cyc(1);
      if (c < 5 && bus_if.gnt == 4'b0001) c1++;
      if (bus_if.expired) nexp++;
    end
    check("burst_first_run", 32'(c1), BURST_EN ? 32'd4 : 32'd5);
    check("burst_expired_cnt", 32'(nexp), BURST_EN ? 32'd4 : 32'd0);
    bus_if.req = 4'b0000;
    cyc(3);

    // lone requester is never preempted
    do_reset();
    bus_if.req = 4'b0001;
    c1 = 0; nexp = 0;
    for (int c = 0; c < 20; c++) begin
      cyc(1);
      if (bus_if.gnt == 4'b0001) c1++;
      if (bus_if.expired) nexp++;
    end
    check("solo_held", 32'(c1), 32'd20);
    check("solo_expired", 32'(nexp), 32'd0);
    bus_if.req = 4'b0000;
    cyc(3);

    // random requests with persistence
    r = 4'b0000;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(7) == 0) r[b] = ~r[b];
      bus_if.req = r;
      cyc(1);
    end
    bus_if.req = 4'b0000;
    cyc(3);

    // asynchronous reset while requester 2 owns the bus
    bus_if.req = 4'b0100;
    c1 = 0;
    for (int c = 0; c < 6 && bus_if.gnt != 4'b0100; c++) begin
      cyc(1);
      c1++;
    end
    check("pre_rst_gnt", 32'(bus_if.gnt), 32'h4);
    bus_if.req = 4'hF;
    rst = 1'b1;
    #1;
    check("mid_rst_gnt", 32'(bus_if.gnt), 32'h0);
    check("mid_rst_sel", 32'(bus_if.sel), 32'h0);
    check("mid_rst_active", 32'(bus_if.active), 32'h0);
    cyc(1);
    rst = 1'b0;
    cyc(1);
    check("post_rst_gnt", 32'(bus_if.gnt), 32'h1);
    bus_if.req = 4'b0000;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter4.md
# bus_arbiter4

Four-requester round-robin arbiter that owns the select of the CPU's shared 32-bit 4:1 source multiplexer (e.g. memory/bus master port). It grants exactly one requester at a time, drives the mux select code matching the grant, and inserts a one-cycle turnaround between owners so the shared path never switches mid-transfer. An optional burst limit forces an owner to yield when others are waiting.

## Interface
- MAX_BURST, default 8: maximum consecutive granted cycles before forced release (burst limit only); legal range 2..255.
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  level request per requester; bit i = requester i; held high for whole transfer.
- gnt  output  4  registered one-hot grant; all-zero when no owner.
- sel  output  2  registered mux select code = index of current/last owner (drives mux ctrl).
- active  output  1  registered; 1 while any gnt bit is set.
- expired  output  1  registered one-cycle pulse on forced release (burst limit only; else tied 0).

## Operation
- States: IDLE, BUSY, TURN. Reset: state=IDLE, gnt=0000, sel=00, active=0, expired=0, last owner pointer=3 (so requester 0 has top priority first), burst counter=0.
- Arbitration (performed in IDLE and TURN): search req starting at (last+1) mod 4, wrapping upward; first set bit wins. Winner recorded as new last owner.
- IDLE: req=0000 -> stay. Any req -> BUSY, gnt=onehot(winner), sel=winner, active=1, counter=0.
- BUSY: req[owner]=1 -> stay, counter increments, saturating at MAX_BURST-1. req[owner]=0 -> TURN, gnt=0000, active=0, sel unchanged. Requests from non-owners ignored except for burst check.
- TURN: exactly one cycle. Arbitrate as in IDLE: winner -> BUSY with new grant; none -> IDLE. sel changes only on entry to BUSY.
- Forced release (burst limit): in BUSY, counter==MAX_BURST-1 and req[owner]=1 and any other req bit set -> TURN, expired=1 for that cycle. The preempted owner, if still requesting, is lowest priority in TURN arbitration (pointer rotation). If no other req, owner keeps grant indefinitely, counter held saturated.
- Owner never sees gnt drop while its req is high, except by forced release.
- gnt, sel, active, expired are flop outputs; no combinational path req->gnt.

## Timing
- Grant latency from IDLE: req sampled high at edge k -> gnt valid after edge k (1 cycle).
- Owner release: req[owner] low sampled at edge k -> gnt=0000 after k; next owner gnt after edge k+1 (one dead cycle guaranteed).
- Back-to-back owners: minimum one cycle with gnt=0000 between any two grants, including same requester re-granted.
- Burst: owner holds gnt for exactly MAX_BURST cycles when preempted; expired high in the first TURN cycle.
- Simultaneous release and new requests: handled via TURN as above; no request lost while held high.
- Request dropped by a non-owner before being granted: simply not considered; no memory of past requests.
- rst asserted mid-transfer: all outputs to reset values immediately (asynchronous), pointer=3; on deassert resume from IDLE.

## Configuration
- ARB_BURST_LIMIT_EN defined: burst counter, forced release and expired pulse implemented as above; MAX_BURST honoured.
- Not defined: no counter; owner keeps grant until it drops req; expired tied to 0; MAX_BURST ignored.

## Test plan
- Reset then req=0001 -> gnt=0001, sel=00, active=1 one cycle later; drop req -> gnt=0000 next cycle, sel stays 00, returns IDLE.
- req=1111 held, each owner drops req after 3 grant cycles -> grant order 0001,0010,0100,1000,0001 with one gnt=0000 cycle between each; sel 0,1,2,3,0.
- Owner 2 granted, req=0100; raise req=1101 mid-burst -> no change until 2 releases; then TURN, next grant 1000 (pointer after 2).
- ARB_BURST_LIMIT_EN, MAX_BURST=4: req=0011 held continuously -> 0001 for 4 cycles, expired=1 and gnt=0000 one cycle, 0010 for 4 cycles, repeat; without macro -> 0001 held forever.
- ARB_BURST_LIMIT_EN, only req=0001 held 20 cycles -> gnt=0001 continuously, expired never asserts.
- Assert rst while gnt=0100 -> gnt=0000, sel=00, active=0 immediately; release rst with req=1111 -> first grant 0001.
